pipe_scheduler: RTL

PIPE_SCHEDULER -- requirements
Module: pipe_scheduler

---
 rtl/pipe_scheduler.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_scheduler.sv
// Scrolling pipe column generator: paces shifts of an external column register,
// emits the pipe/gap bit pattern, picks gap rows and keeps score. Build option: PIPE_SPEEDUP_EN.
module pipe_scheduler #(
    parameter int         SHIFT_PERIOD = 12500000,
    parameter int         PIPE_WIDTH   = 3,
    parameter int         PIPE_GAP     = 5,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       pause,
    input  logic       game_over,
    input  logic       col_exit,
    output logic       shift_pulse,
    output logic       data_out,
    output logic [2:0] gap_row,
    output logic [1:0] state,
    output logic [7:0] score
);

    localparam int CW      = $clog2(SHIFT_PERIOD + 1);
    localparam int PAT_LEN = PIPE_WIDTH + PIPE_GAP;
    localparam int PW      = $clog2(PAT_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   period_cur;
    logic [PW-1:0]   pos_reg;
    logic            data_reg;
    logic [7:0]      lfsr_reg, lfsr_next;
    logic [2:0]      gap_reg;
    logic [7:0]      score_reg, score_next;
    logic            exit_prev_reg;
    logic            at_wrap;
    logic            start_play;
    logic            restart;
    logic            pipe_start;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (start) state_next = ST_RUN;
            ST_RUN:   if (game_over) state_next = ST_HALT;
                      else if (pause) state_next = ST_PAUSE;
            ST_PAUSE: if (game_over) state_next = ST_HALT;
                      else if (!pause) state_next = ST_RUN;
            ST_HALT:  if (start) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // The pulse is withheld on a collision cycle so the register never moves after game over.
    always_comb begin
        shift_pulse = at_wrap && !game_over;
        state       = state_reg;
        data_out    = data_reg;
        gap_row     = gap_reg;
        score       = score_reg;
    end

    assign at_wrap    = (state_reg == ST_RUN) && (cnt_reg == period_cur - CW'(1));
    assign start_play = (state_reg == ST_IDLE) && start;
    assign restart    = (state_reg == ST_HALT) && start;

    // ---------------- period counter ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt_reg <= '0;
        else if (state_reg == ST_RUN)
            cnt_reg <= at_wrap ? '0 : cnt_reg + CW'(1);
        else if (state_reg != ST_PAUSE)
            cnt_reg <= '0;
    end

`ifdef PIPE_SPEEDUP_EN
    localparam logic [31:0] SP_FULL = 32'(SHIFT_PERIOD);
    localparam logic [31:0] SP_HALF = 32'(SHIFT_PERIOD / 2);
    localparam logic [31:0] SP_STEP = 32'(SHIFT_PERIOD / 8);

    function automatic logic [CW-1:0] eff_period(input logic [7:0] sc);
        logic [31:0] red;
        red = 32'(sc[7:3]) * SP_STEP;
        if (red > SP_FULL - SP_HALF)
            return CW'(SP_HALF);
        else
            return CW'(SP_FULL - red);
    endfunction

    logic [CW-1:0] period_reg;

    // New speed is adopted only at a wrap (or while stopped) so a period never changes mid-count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            period_reg <= CW'(SHIFT_PERIOD);
        else if (at_wrap || state_reg == ST_IDLE || state_reg == ST_HALT)
            period_reg <= eff_period(score_next);
    end

    assign period_cur = period_reg;
`else
    assign period_cur = CW'(SHIFT_PERIOD);
`endif

    // ---------------- column pattern ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pos_reg  <= '0;
            data_reg <= 1'b0;
        end else if (restart) begin
            pos_reg  <= '0;
            data_reg <= 1'b0;
        end else if (start_play) begin
            pos_reg  <= PW'(1);
            data_reg <= 1'b1;
        end else if (shift_pulse) begin
            data_reg <= (pos_reg < PW'(PIPE_WIDTH));
            pos_reg  <= (pos_reg == PW'(PAT_LEN - 1)) ? '0 : pos_reg + PW'(1);
        end
    end

    // ---------------- gap-row LFSR ----------------
    assign pipe_start   = start_play || (shift_pulse && pos_reg == '0);
    assign lfsr_next[0] = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_lfsr_shift
            assign lfsr_next[gi] = lfsr_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_reg <= LFSR_SEED;
            gap_reg  <= 3'd0;
        end else if (pipe_start) begin
            lfsr_reg <= lfsr_next;
            gap_reg  <= lfsr_next[2:0];
        end
    end

    // ---------------- score ----------------
    // A pipe has passed once its trailing '1' column leaves the register.
    always_comb begin
        score_next = score_reg;
        if (restart)
            score_next = 8'd0;
        else if (shift_pulse && !col_exit && exit_prev_reg && score_reg != 8'hFF)
            score_next = score_reg + 8'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            score_reg     <= 8'd0;
            exit_prev_reg <= 1'b0;
        end else begin
            score_reg <= score_next;
            if (restart)
                exit_prev_reg <= 1'b0;
            else if (shift_pulse)
                exit_prev_reg <= col_exit;
        end
    end

endmodule
